// File: rtl/conv_seq_if.sv
// Handshake and bus signals between the convolution sequencer and its surroundings
// (pixel RAM, stage1 front end, stage3 adder, output buffer).
interface conv_seq_if #(
   parameter int ADDR_W = 10
);
   logic              start;
   logic              abort;
   logic              stall;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic              pix_valid;
   logic              win_valid;
   logic              res_valid;
   logic signed [14:0] res_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              busy;
   logic              done;
   logic              err;

   // Sequencer side
   modport slave (
      input  start, abort, stall, res_valid, res_data,
      output rd_en, rd_addr, pix_valid, win_valid,
      output wr_en, wr_addr, wr_data, busy, done, err
   );

   // Controller / environment side
   modport master (
      output start, abort, stall, res_valid, res_data,
      input  rd_en, rd_addr, pix_valid, win_valid,
      input  wr_en, wr_addr, wr_data, busy, done, err
   );
endinterface

// File: rtl/conv_sequencer.sv
// Control FSM for the 3x3 convolution accelerator: raster-scans the pixel RAM, flags
// window-completing pixels and writes saturated adder results to the output buffer.
module conv_sequencer #(
   parameter int IMG_W     = 32,
   parameter int IMG_H     = 32,
   parameter int ADDR_W    = 10,
   parameter int OUT_SHIFT = 0
) (
   input logic      clk,
   input logic      rst_n,
   conv_seq_if.slave bus
);

   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int CNT_W = ADDR_W + 1;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
   localparam logic [CNT_W-1:0]  N_RES     = CNT_W'((IMG_W - 2) * (IMG_H - 2));
   localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_DRAIN,
      S_DONE
   } state_e;

   state_e            state_q;
   logic              rd_en_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [COL_W-1:0]  rd_col_q;
   logic [ROW_W-1:0]  rd_row_q;
   logic              pix_valid_q;
   logic              win_valid_q;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [7:0]        wr_data_q;
   logic [CNT_W-1:0]  wr_cnt_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;

   logic signed [14:0] shifted;
   logic [7:0]         sat_data;
   logic               in_frame;
   logic               res_accept;
   logic               rd_win;

   // Clamp the shifted signed result into the unsigned 8-bit pixel range.
   always_comb begin
      shifted = bus.res_data >>> OUT_SHIFT;
      if (shifted[14]) begin
         sat_data = 8'h00;
      end else if (shifted > 15'sd255) begin
         sat_data = 8'hFF;
      end else begin
         sat_data = shifted[7:0];
      end
   end

   assign in_frame   = (state_q == S_FILL) || (state_q == S_DRAIN);
   assign res_accept = in_frame && bus.res_valid && (wr_cnt_q < N_RES);
   assign rd_win     = (rd_row_q >= ROW_W'(2)) && (rd_col_q >= COL_W'(2));

   // NOTE: every register is updated with non-blocking assignments so that all
   // decisions in this block see the values from before the clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         rd_col_q    <= '0;
         rd_row_q    <= '0;
         pix_valid_q <= 1'b0;
         win_valid_q <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         wr_cnt_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else if (bus.abort) begin
         // Abort drops the frame but keeps the sticky error for the host to read.
         state_q     <= S_IDLE;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         rd_col_q    <= '0;
         rd_row_q    <= '0;
         pix_valid_q <= 1'b0;
         win_valid_q <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         wr_cnt_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         pix_valid_q <= rd_en_q;
         win_valid_q <= rd_en_q && rd_win;
         wr_en_q     <= 1'b0;
         done_q      <= 1'b0;

         if (res_accept) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= wr_cnt_q[ADDR_W-1:0];
            wr_data_q <= sat_data;
            wr_cnt_q  <= wr_cnt_q + 1'b1;
         end

         if (bus.res_valid && !res_accept) begin
            err_q <= 1'b1;
         end else if (bus.start && (state_q == S_IDLE)) begin
            err_q <= 1'b0;
         end

         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_q   <= S_FILL;
                  busy_q    <= 1'b1;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= '0;
                  rd_col_q  <= '0;
                  rd_row_q  <= '0;
                  wr_cnt_q  <= '0;
               end
            end

            S_FILL: begin
               // rd_en_q high means the read at rd_addr_q went out this cycle.
               if (rd_en_q) begin
                  if (rd_addr_q == LAST_ADDR) begin
                     state_q <= S_DRAIN;
                     rd_en_q <= 1'b0;
                  end else begin
                     rd_addr_q <= rd_addr_q + 1'b1;
                     rd_en_q   <= !bus.stall;
                     if (rd_col_q == LAST_COL) begin
                        rd_col_q <= '0;
                        rd_row_q <= rd_row_q + 1'b1;
                     end else begin
                        rd_col_q <= rd_col_q + 1'b1;
                     end
                  end
               end else begin
                  rd_en_q <= !bus.stall;
               end
            end

            S_DRAIN: begin
               if (wr_cnt_q == N_RES) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end

            S_DONE: begin
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.rd_en     = rd_en_q;
   assign bus.rd_addr   = rd_addr_q;
   assign bus.pix_valid = pix_valid_q;
   assign bus.win_valid = win_valid_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: a stage3 stand-in answers every window with a
// result, and a scoreboard queue holds the write each result must produce.
module tb_conv_sequencer;

   localparam int IMG_W     = 32;
   localparam int IMG_H     = 32;
   localparam int ADDR_W    = 10;
   localparam int OUT_SHIFT = 0;
   localparam int NPIX      = IMG_W * IMG_H;
   localparam int NRES      = (IMG_W - 2) * (IMG_H - 2);
   localparam int BUDGET    = 4000;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   conv_seq_if #(.ADDR_W(ADDR_W)) bus ();

   conv_sequencer #(
      .IMG_W    (IMG_W),
      .IMG_H    (IMG_H),
      .ADDR_W   (ADDR_W),
      .OUT_SHIFT(OUT_SHIFT)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         addr;
      logic [7:0] data;
   } wr_exp_t;

   typedef struct {
      int         v;
      logic [7:0] e;
   } res_t;

   wr_exp_t sb[$];
   res_t    pend[$];

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   int         sat_vec [5] = '{-5, 100, 300, -16384, 16383};
   logic [7:0] sat_exp [5] = '{8'd0, 8'd100, 8'd255, 8'd0, 8'd255};
   int         vec_idx;

   int rd_count, win_count, wr_count, done_count, exp_rd_addr, wr_idx;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] sat8(input int v);
      int s;
      s = v >>> OUT_SHIFT;
      if (s < 0) return 8'd0;
      if (s > 255) return 8'd255;
      return s[7:0];
   endfunction

   function automatic logic [5:0] ctrl_bits();
      return {bus.rd_en, bus.pix_valid, bus.win_valid, bus.wr_en, bus.busy, bus.done};
   endfunction

   // Runs one frame from a negedge; returns at a negedge.
   task automatic run_frame(input int stall_addr, input int abort_read, input bit extra_res,
                            input bit rst_drain, input bit busy_start);
      int   cyc        = 0;
      int   stall_left = 0;
      int   post       = -1;
      bit   stall_done = 0;
      bit   abort_sent = 0;
      bit   extra_sent = 0;
      bit   bs_done    = 0;
      bit   early_exit = 0;
      res_t r;
      int   raw;

      rd_count = 0; win_count = 0; wr_count = 0; done_count = 0; exp_rd_addr = 0; wr_idx = 0;
      sb.delete();
      pend.delete();

      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("first_rd_en", bus.rd_en, 1);
      check("first_rd_addr", bus.rd_addr, 0);
      check("busy_in_fill", bus.busy, 1);
      check("err_cleared_by_start", bus.err, 0);

      while (1) begin
         if (abort_sent) begin
            bus.abort = 1'b0; bus.start = 1'b0; bus.res_valid = 1'b0;
            check("abort_ctrl_zero", ctrl_bits(), 0);
            check("abort_rd_addr_zero", bus.rd_addr, 0);
            check("abort_wr_addr_zero", bus.wr_addr, 0);
            check("abort_err_kept", bus.err, 0);
            early_exit = 1;
            break;
         end
         if (stall_left > 0) begin
            check("stall_rd_en_low", bus.rd_en, 0);
            check("stall_rd_addr_hold", bus.rd_addr, stall_addr);
            stall_left--;
            if (stall_left == 0) bus.stall = 1'b0;
         end
         if (bus.rd_en) begin
            check("rd_addr_seq", bus.rd_addr, exp_rd_addr);
            exp_rd_addr++;
            rd_count++;
         end
         if (bus.win_valid) begin
            win_count++;
            if (vec_idx < 5) begin
               r.v = sat_vec[vec_idx];
               r.e = sat_exp[vec_idx];
               vec_idx++;
            end else begin
               raw = int'($urandom_range(0, 32767));
               r.v = ($urandom_range(0, 2) == 0) ? raw - 16384 : int'($urandom_range(0, 400)) - 50;
               r.e = sat8(r.v);
            end
            pend.push_back(r);
         end
         if (bus.wr_en) begin
            wr_count++;
            check("wr_has_expectation", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               wr_exp_t w;
               w = sb.pop_front();
               check("wr_addr", bus.wr_addr, w.addr);
               check("wr_data", bus.wr_data, w.data);
            end
         end
         if (bus.done) begin
            done_count++;
            check("done_with_busy_low", bus.busy, 0);
            if (post < 0) post = 3;
         end
         if (rst_drain && rd_count == NPIX && wr_count == NRES - 3) begin
            check("drain_busy", bus.busy, 1);
            bus.res_valid = 1'b0;
            rst_n = 1'b0;
            #1;
            check("rst_ctrl_zero", ctrl_bits(), 0);
            check("rst_bus_zero", {bus.rd_addr, bus.wr_addr, bus.wr_data}, 0);
            check("rst_err_zero", bus.err, 0);
            early_exit = 1;
            break;
         end

         bus.start = 1'b0;
         bus.res_valid = 1'b0;
         if (stall_addr >= 0 && !stall_done && bus.rd_en && bus.rd_addr == ADDR_W'(stall_addr - 1)) begin
            bus.stall  = 1'b1;
            stall_left = 10;
            stall_done = 1;
         end
         if (busy_start && !bs_done && rd_count == 200) begin
            bus.start = 1'b1;
            bs_done   = 1;
         end
         if (abort_read >= 0 && exp_rd_addr == abort_read) begin
            bus.abort     = 1'b1;
            bus.start     = 1'b1;
            bus.res_valid = 1'b1;
            bus.res_data  = 15'sd77;
            abort_sent    = 1;
         end else if (pend.size() > 0) begin
            r = pend.pop_front();
            bus.res_valid = 1'b1;
            bus.res_data  = r.v[14:0];
            sb.push_back('{wr_idx, r.e});
            wr_idx++;
         end else if (extra_res && !extra_sent && wr_idx == NRES) begin
            bus.res_valid = 1'b1;
            bus.res_data  = 15'sd42;
            extra_sent    = 1;
         end

         if (post > 0) begin
            post--;
            if (post == 0) break;
         end
         cyc++;
         if (cyc > BUDGET) begin
            check("frame_within_budget", done_count, 1);
            break;
         end
         @(negedge clk);
      end

      bus.start = 1'b0;
      bus.res_valid = 1'b0;
      if (!early_exit) begin
         check("read_count", rd_count, NPIX);
         check("win_count", win_count, NRES);
         check("write_count", wr_count, NRES);
         check("done_pulses", done_count, 1);
         check("scoreboard_empty", sb.size(), 0);
         check("err_at_end", bus.err, extra_res);
         if (extra_res) check("extra_result_sent", extra_sent, 1);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.abort = 1'b0; bus.stall = 1'b0;
      bus.res_valid = 1'b0; bus.res_data = '0;
      vec_idx = 0;

      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset_ctrl_zero", ctrl_bits(), 0);
      check("reset_bus_zero", {bus.rd_addr, bus.wr_addr, bus.wr_data}, 0);
      check("reset_err_zero", bus.err, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Full frame with saturation vectors first and a start pulse while busy
      run_frame(-1, -1, 1'b0, 1'b0, 1'b1);

      // Stall at address 37
      run_frame(37, -1, 1'b0, 1'b0, 1'b0);

      // Abort at read 500 together with start and res_valid, then a clean frame
      run_frame(-1, 500, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("post_abort_idle", ctrl_bits(), 0);
      run_frame(-1, -1, 1'b0, 1'b0, 1'b0);

      // Result while idle raises err without a write
      bus.res_valid = 1'b1;
      bus.res_data  = 15'sd50;
      @(negedge clk);
      bus.res_valid = 1'b0;
      check("idle_res_err", bus.err, 1);
      check("idle_res_no_write", bus.wr_en, 0);
      @(negedge clk);
      check("idle_res_no_write_later", bus.wr_en, 0);

      // One result beyond the expected count during drain
      run_frame(-1, -1, 1'b1, 1'b0, 1'b0);

      // Asynchronous reset in drain, with an ignored start while busy
      run_frame(-1, -1, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("after_reset_idle", ctrl_bits(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
